seg_carry_adder_pipe: RTL and testbench
=======================================

Name: seg_carry_adder_pipe

Overview:
- Pipelined wide adder/subtractor that consumes the per-segment carry-chain results (O, CO[7]) produced by 8-bit carry-chain cells.
- Splits a WIDTH-bit add into 8-bit segments and registers the inter-segment carry between pipeline stages, so each stage's critical path is one segment chain.
- Skews operands on entry and deskews sums on exit; streams one operation per cycle under a valid/ready handshake.
- Sits between operand-producing datapaths (multiplier partial-sum trees, accumulators) and downstream result consumers.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of 8·SEGS_PER_STAGE; elaboration error otherwise.
- SEGS_PER_STAGE, 1, 8-bit segments chained combinationally per pipeline stage (1, 2 or 4). NUM_STAGES = WIDTH/(8·SEGS_PER_STAGE).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block accepts input this cycle
- in_a  in  WIDTH  operand A, unsigned/two's complement
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = subtract (A + ~B + carry-in)
- in_cin  in  1  carry-in; in subtract mode, borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  A±B result
- out_cout  out  1  carry out of MSB (inverted borrow when subtracting)
- out_ovf  out  1  signed overflow of the WIDTH-bit result

Behaviour:
- Effective B' = in_sub ? ~in_b : in_b; effective carry-in c0 = in_sub ? ~in_cin : in_cin.
  - in_sub=1, in_cin=0 gives A−B; in_sub=1, in_cin=1 gives A−B−1.
- Per segment, computed exactly as the carry cell expects:
  - propagate S = a_seg ^ b'_seg; generate DI = a_seg.
  - sum = S ^ carry vector; carry-out = CO[7].
- Stage k (0..NUM_STAGES−1) adds segments [k·SEGS_PER_STAGE, (k+1)·SEGS_PER_STAGE) using the carry registered by stage k−1; stage 0 uses c0.
- Skew: operand slices for stage k are delayed k cycles. Deskew: sum slices from stage k are delayed NUM_STAGES−1−k cycles. All slices of one operation emerge together.
- Latency: exactly NUM_STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, with no back-pressure.
- Throughput: one operation per cycle.
- out_ovf = carry into MSB XOR carry out of MSB, evaluated in the last stage.
- Handshake:
  - Global advance enable: adv = ~out_valid | out_ready. in_ready = adv, driven combinationally from out_ready and out_valid only; it never depends on in_valid.
  - When adv=0 every pipeline register, including skew and deskew, holds.
  - Per-stage valid bits shift on adv. Bubbles (in_valid=0) propagate as invalid slots and do not collapse.
  - out_valid is held high with out_sum, out_cout and out_ovf stable until out_ready.
  - Simultaneous accept and emit in one cycle is legal: full-rate streaming with out_ready=1.
- Reset (async assert, release synchronised by the existing reset tree):
  - All valid bits = 0; out_valid = 0; out_sum = 0; out_cout = 0; out_ovf = 0. in_ready = 1 after reset.
  - Reset mid-operation discards every in-flight operation with no partial output.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only through out_cout and out_ovf.
- Data registers need no reset, but outputs must read 0 while out_valid=0 after reset.

Optional Feature:
- Macro CARRY8_PRIM_EN.
- Defined: each 8-bit segment instantiates the CARRY8 primitive with CARRY_TYPE "SINGLE_CY8", CI = incoming carry, DI = a_seg, S = propagate; sum from O, carry from CO[7].
- Undefined: behavioural 9-bit add per segment.
- Results, latency and handshake are bit- and cycle-identical in both builds; the bench runs both.

Test Plan:
- WIDTH=32, SEGS_PER_STAGE=1: A=0xFFFF_FFFF, B=0x0000_0001, sub=0, cin=0 -> after 4 cycles sum=0x0000_0000, cout=1, ovf=0 (ripple through all stages).
- A=0x7FFF_FFFF, B=0x1, add -> sum=0x8000_0000, cout=0, ovf=1. A=0x0000_0005, B=0x0000_0007, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Stream 1000 random ops back-to-back with out_ready=1 -> in_ready never low, one result per cycle, order preserved, all sums match a reference model.
- Hold out_ready=0 for 6 cycles with the pipe full -> in_ready=0, outputs stable; on release, results resume with no loss or duplication.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0 and out_sum=0 immediately; after release, no stale result appears and a new op returns after 4 cycles.
- SEGS_PER_STAGE=2, WIDTH=64 with alternating bubbles, both with and without CARRY8_PRIM_EN -> latency 4 cycles, outputs identical.

Source files
------------

// File: rtl/seg_carry_adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor built from 8-bit carry-chain segments, SEGS_PER_STAGE per stage.
// Define CARRY8_PRIM_EN to map every segment onto the CARRY8 primitive instead of a behavioural add.

module seg_carry_adder_pipe_seg8 (
    input  logic [7:0] a,
    input  logic [7:0] bp,
    input  logic       ci,
    output logic [7:0] o,
    output logic       co
);
`ifdef CARRY8_PRIM_EN
    logic [7:0] prop;
    logic [7:0] co_vec;

    assign prop = a ^ bp;

    CARRY8 #(
        .CARRY_TYPE("SINGLE_CY8")
    ) u_carry8 (
        .CO    (co_vec),
        .O     (o),
        .CI    (ci),
        .CI_TOP(1'b0),
        .DI    (a),
        .S     (prop)
    );

    assign co = co_vec[7];
`else
    logic [8:0] sum9;

    assign sum9 = {1'b0, a} + {1'b0, bp} + {8'd0, ci};
    assign o    = sum9[7:0];
    assign co   = sum9[8];
`endif
endmodule

module seg_carry_adder_pipe #(
    parameter int WIDTH          = 32,
    parameter int SEGS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int SEG_W      = 8 * SEGS_PER_STAGE;
    localparam int NUM_STAGES = WIDTH / SEG_W;
    localparam int NUM_SEGS   = WIDTH / 8;

    if (((SEGS_PER_STAGE != 1) && (SEGS_PER_STAGE != 2) && (SEGS_PER_STAGE != 4)) ||
        (WIDTH < SEG_W) || ((WIDTH % SEG_W) != 0)) begin : g_bad_param
        $error("seg_carry_adder_pipe: WIDTH must be a multiple of 8*SEGS_PER_STAGE, SEGS_PER_STAGE in {1,2,4}");
    end

    // vld_pipe_q[0] tags the operand entry register, vld_pipe_q[k+1] the output of stage k.
    logic [NUM_STAGES:0]                 vld_pipe_q, vld_pipe_d;
    logic [NUM_STAGES-1:0][WIDTH-1:0]    a_q, a_d, bp_q, bp_d, sum_q, sum_d;
    logic [NUM_STAGES-1:0]               cy_q, cy_d;
    logic                                c0_q, c0_d;
    logic                                ovf_q, ovf_d;
    logic                                adv;

    logic [WIDTH-1:0] sum_in [NUM_STAGES];
    logic             cy_in  [NUM_STAGES];
    logic [7:0]       seg_o  [NUM_SEGS];
    logic             seg_co [NUM_SEGS];
    logic             seg_ci [NUM_SEGS];

    assign adv      = ~vld_pipe_q[NUM_STAGES] | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign sum_in[k] = '0;
            assign cy_in[k]  = c0_q;
        end else begin : g_next
            assign sum_in[k] = sum_q[k-1];
            assign cy_in[k]  = cy_q[k-1];
        end
    end

    // Segment g works on the operand copy that has been skewed to reach stage g/SEGS_PER_STAGE.
    for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
        localparam int K = g / SEGS_PER_STAGE;
        if ((g % SEGS_PER_STAGE) == 0) begin : g_stage_ci
            assign seg_ci[g] = cy_in[K];
        end else begin : g_chain_ci
            assign seg_ci[g] = seg_co[g-1];
        end
        seg_carry_adder_pipe_seg8 u_seg (
            .a (a_q[K][8*g +: 8]),
            .bp(bp_q[K][8*g +: 8]),
            .ci(seg_ci[g]),
            .o (seg_o[g]),
            .co(seg_co[g])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        a_d        = a_q;
        bp_d       = bp_q;
        sum_d      = sum_q;
        cy_d       = cy_q;
        c0_d       = c0_q;
        ovf_d      = ovf_q;
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[NUM_STAGES-1:0], in_valid};
            a_d[0]     = in_a;
            bp_d[0]    = in_sub ? ~in_b : in_b;
            c0_d       = in_sub ? ~in_cin : in_cin;
            for (int k = 1; k < NUM_STAGES; k++) begin
                a_d[k]  = a_q[k-1];
                bp_d[k] = bp_q[k-1];
            end
            // Each stage overlays its own slices onto the partial sum it inherits (deskew).
            for (int k = 0; k < NUM_STAGES; k++) begin
                sum_d[k] = sum_in[k];
                for (int s = 0; s < SEGS_PER_STAGE; s++) begin
                    sum_d[k][8*(k*SEGS_PER_STAGE+s) +: 8] = seg_o[k*SEGS_PER_STAGE+s];
                end
                cy_d[k] = seg_co[(k+1)*SEGS_PER_STAGE-1];
            end
            // Carry into the MSB is recovered as propagate ^ sum at that bit.
            ovf_d = seg_co[NUM_SEGS-1] ^ a_q[NUM_STAGES-1][WIDTH-1]
                  ^ bp_q[NUM_STAGES-1][WIDTH-1] ^ seg_o[NUM_SEGS-1][7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        bp_q  <= bp_d;
        sum_q <= sum_d;
        cy_q  <= cy_d;
        c0_q  <= c0_d;
        ovf_q <= ovf_d;
    end

    // Operand bits below each stage's slice are already consumed; synthesis prunes them.
    logic unused_skew_bits;
    assign unused_skew_bits = ^{a_q, bp_q};

    assign out_valid = vld_pipe_q[NUM_STAGES];
    assign out_sum   = out_valid ? sum_q[NUM_STAGES-1] : '0;
    assign out_cout  = out_valid & cy_q[NUM_STAGES-1];
    assign out_ovf   = out_valid & ovf_q;
endmodule

// File: tb/tb_seg_carry_adder_pipe.sv
// Bench for seg_carry_adder_pipe: a 32-bit/1-seg and a 64-bit/2-seg instance share one stimulus
// stream and are scored against an arithmetic reference model.

module tb_seg_carry_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
    logic [63:0] in_a = '0, in_b = '0;

    logic        in_ready32, out_valid32, out_cout32, out_ovf32;
    logic [31:0] out_sum32;
    logic        in_ready64, out_valid64, out_cout64, out_ovf64;
    logic [63:0] out_sum64;

    int n_checks = 0, n_pass = 0, n_out32 = 0, n_out64 = 0;
    logic [65:0] q32[$];
    logic [65:0] q64[$];

    always #5 clk = ~clk;

    seg_carry_adder_pipe #(.WIDTH(32), .SEGS_PER_STAGE(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid32), .out_ready(out_ready), .out_sum(out_sum32),
        .out_cout(out_cout32), .out_ovf(out_ovf32)
    );

    seg_carry_adder_pipe #(.WIDTH(64), .SEGS_PER_STAGE(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid64), .out_ready(out_ready), .out_sum(out_sum64),
        .out_cout(out_cout64), .out_ovf(out_ovf64)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic at width w.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic sub, input logic cin);
        logic signed [67:0] pw, half, xa, xb, ci, r, sa, sb, sr;
        logic [63:0] mask;
        logic co, ov;
        pw   = 68'sd1 <<< w;
        half = pw >>> 1;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        xa   = {4'b0, a & mask};
        xb   = {4'b0, b & mask};
        ci   = {67'b0, cin};
        sa   = (xa >= half) ? xa - pw : xa;
        sb   = (xb >= half) ? xb - pw : xb;
        if (sub) begin
            r  = xa - xb - ci;
            co = (r >= 0);
            sr = sa - sb - ci;
        end else begin
            r  = xa + xb + ci;
            co = (r >= pw);
            sr = sa + sb + ci;
        end
        ov = (sr >= half) || (sr < -half);
        return {ov, co, r[63:0] & mask};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_8000_0000;
            3:       return 64'h7FFF_FFFF_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: the negedge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready32) q32.push_back(ref_op(32, in_a, in_b, in_sub, in_cin));
            if (in_valid && in_ready64) q64.push_back(ref_op(64, in_a, in_b, in_sub, in_cin));
            if (out_valid32 && out_ready) begin
                n_out32++;
                if (q32.size() == 0) chk("sb32_unexpected_result", 66'd1, 66'd0);
                else chk("sb32_result", {out_ovf32, out_cout32, 32'h0, out_sum32}, q32.pop_front());
            end
            if (out_valid64 && out_ready) begin
                n_out64++;
                if (q64.size() == 0) chk("sb64_unexpected_result", 66'd1, 66'd0);
                else chk("sb64_result", {out_ovf64, out_cout64, out_sum64}, q64.pop_front());
            end
        end
    end

    // Called at posedge+1 with the pipe idle; returns latency in cycles from the accepting edge.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                           output logic [31:0] s, output logic co, output logic ov, output int lat);
        in_a = {b, a}; in_b = {a, b}; in_sub = sub; in_cin = cin;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat64_matches", {65'd0, out_valid64}, 66'd1);
        s = out_sum32; co = out_cout32; ov = out_ovf32;
    endtask

    // mode 0: full rate; 1: alternating bubbles; 2: full rate with out_ready low for 6 cycles.
    task automatic run_stream(input int n_ops, input int mode);
        int sent, cyc, ready_low, gaps, o32, o64, guard;
        logic pending, fire;
        sent = 0; cyc = 0; ready_low = 0; gaps = 0; guard = 0; pending = 1'b0;
        o32 = n_out32; o64 = n_out64;
        while (sent < n_ops && cyc < 20000) begin
            if (!pending && (mode != 1 || (cyc % 2) == 0)) begin
                in_a = rnd64(); in_b = rnd64();
                in_sub = ($urandom_range(0, 1) != 0);
                in_cin = ($urandom_range(0, 1) != 0);
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = !(mode == 2 && cyc >= 10 && cyc < 16);
            @(negedge clk);
            fire = in_valid && in_ready32;
            if (mode == 0) begin
                if (!in_ready32) ready_low++;
                if (cyc >= 5 && !out_valid32) gaps++;
            end
            if (mode == 2 && cyc >= 10 && cyc < 16) begin
                chk("hold_in_ready32", {65'd0, in_ready32}, 66'd0);
                chk("hold_in_ready64", {65'd0, in_ready64}, 66'd0);
                if (q32.size() == 0) chk("hold_q32_nonempty", 66'd0, 66'd1);
                else chk("hold_out32", {out_ovf32, out_cout32, 32'h0, out_sum32}, q32[0]);
                if (q64.size() == 0) chk("hold_q64_nonempty", 66'd0, 66'd1);
                else chk("hold_out64", {out_ovf64, out_cout64, out_sum64}, q64[0]);
            end
            @(posedge clk); #1;
            if (fire) begin
                pending = 1'b0;
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q32.size() != 0 || q64.size() != 0) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_q32_empty", 66'(q32.size()), 66'd0);
        chk("drain_q64_empty", 66'(q64.size()), 66'd0);
        chk("stream_count32", 66'(n_out32 - o32), 66'(n_ops));
        chk("stream_count64", 66'(n_out64 - o64), 66'(n_ops));
        if (mode == 0) begin
            chk("stream_in_ready_low_cycles", 66'(ready_low), 66'd0);
            chk("stream_output_gaps", 66'(gaps), 66'd0);
            chk("stream_cycles", 66'(cyc), 66'(n_ops));
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        sub, cin;
        logic [31:0] sum;
        logic        cout, ovf;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic cin, input logic [31:0] sum, input logic cout,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin; v.sum = sum; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[10];
        logic [31:0] s;
        logic        co, ov;
        int          lat, stale;
        logic [65:0] e;

        tbl[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        tbl[2] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tbl[3] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        tbl[4] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        tbl[5] = mk(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5679, 1'b0, 1'b0);
        tbl[6] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[7] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        tbl[8] = mk(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
        tbl[9] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        #2;
        chk("rst_out_valid32", {65'd0, out_valid32}, 66'd0);
        chk("rst_outs32", {32'h0, out_cout32, out_ovf32, out_sum32}, 66'd0);
        chk("rst_in_ready32", {65'd0, in_ready32}, 66'd1);
        chk("rst_out_valid64", {65'd0, out_valid64}, 66'd0);
        chk("rst_outs64", {out_cout64, out_ovf64, out_sum64}, 66'd0);
        #20;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_one(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, s, co, ov, lat);
            chk($sformatf("vec%0d_latency", i), 66'(lat), 66'd4);
            chk($sformatf("vec%0d_sum", i), {34'd0, s}, {34'd0, tbl[i].sum});
            chk($sformatf("vec%0d_cout_ovf", i), {64'd0, co, ov}, {64'd0, tbl[i].cout, tbl[i].ovf});
        end
        @(posedge clk); #1;

        run_stream(1000, 0);
        run_stream(40, 2);
        run_stream(200, 1);

        // Three ops in flight, then an asynchronous reset between clock edges.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = rnd64(); in_b = rnd64(); in_sub = 1'b0; in_cin = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid32", {65'd0, out_valid32}, 66'd0);
        chk("midrst_out_sum32", {34'd0, out_sum32}, 66'd0);
        chk("midrst_out_valid64", {65'd0, out_valid64}, 66'd0);
        chk("midrst_out_sum64", {2'd0, out_sum64}, 66'd0);
        chk("midrst_in_ready32", {65'd0, in_ready32}, 66'd1);
        q32.delete();
        q64.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid32 || out_valid64) stale++;
            @(posedge clk); #1;
        end
        chk("postrst_no_stale", 66'(stale), 66'd0);
        run_one(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0, s, co, ov, lat);
        e = ref_op(32, 64'hDEAD_BEEF, 64'h2152_4111, 1'b1, 1'b0);
        chk("postrst_latency", 66'(lat), 66'd4);
        chk("postrst_result", {ov, co, 32'h0, s}, e);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
